// File: rtl/lfsr_sched.sv
// lfsr_sched: 5-bit Fibonacci LFSR stepped by a programmable tick divider. Each
// fresh value is handed to exactly one requester through round-robin arbitration.
module lfsr_sched #(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIV_W-1:0]   div_val,
    input  logic               step_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [4:0]         rnd_data,
    output logic               rnd_valid,
    output logic [4:0]         lfsr_q,
    output logic               tick
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        EMPTY,
        READY,
        GRANT
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   count;
    logic [PTR_W-1:0]   rr_ptr;

    logic               wrap;
    logic               advance;
    logic [4:0]         lfsr_next;
    logic [PTR_W:0]     pick;
    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;

    // First set request at or after the pointer, wrapping; MSB flags a hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [PTR_W-1:0]   ptr);
        logic             found;
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && r[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] sel);
        return PTR_W'((int'(sel) + 1) % NUM_REQ);
    endfunction

    assign wrap      = (count >= div_val);
    assign advance   = step_en && wrap;
    assign lfsr_next = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    assign pick      = rr_pick(req, rr_ptr);
    assign pick_vld  = pick[PTR_W];
    assign pick_idx  = pick[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            count     <= '0;
            rr_ptr    <= '0;
            lfsr_q    <= 5'b00001;
            tick      <= 1'b0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            tick      <= 1'b0;

            if (step_en) begin
                if (wrap) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + DIV_W'(1);
                end
            end

            // The all-zero state would lock the LFSR forever, so it wins over an advance.
            if (lfsr_q == 5'b00000) begin
                lfsr_q <= 5'b00001;
            end else if (advance) begin
                lfsr_q <= lfsr_next;
            end

            case (state)
                EMPTY: begin
                    if (advance) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (|req) begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (pick_vld) begin
                        gnt       <= NUM_REQ'(1) << pick_idx;
                        rnd_data  <= lfsr_q;
                        rnd_valid <= 1'b1;
                        rr_ptr    <= ptr_after(pick_idx);
                        // A value arriving on the grant edge is fresh and still unclaimed.
                        state     <= advance ? READY : EMPTY;
                    end else begin
                        state <= READY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_sched.sv
// Bench for lfsr_sched: directed vector table, hand-written corner sequences and
// randomized traffic, all compared each cycle against an abstract reference model.
module tb_lfsr_sched;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] div_val;
    logic          step_en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [4:0]    rnd_data;
    logic          rnd_valid;
    logic [4:0]    lfsr_q;
    logic          tick;

    lfsr_sched #(.NUM_REQ(N), .DIV_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .div_val  (div_val),
        .step_en  (step_en),
        .req      (req),
        .gnt      (gnt),
        .rnd_data (rnd_data),
        .rnd_valid(rnd_valid),
        .lfsr_q   (lfsr_q),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain integers and two flags (value pending, request seen).
    int m_lfsr, m_cnt, m_ptr, m_gnt, m_rd;
    bit m_fresh, m_armed, m_rv, m_tick;

    function automatic int lfsr_step(int v);
        return ((v << 1) & 31) | (((v >> 4) ^ (v >> 2)) & 1);
    endfunction

    task automatic model_edge();
        int old;
        int idx;
        bit adv;
        if (!reset) begin
            m_lfsr = 1; m_cnt = 0; m_ptr = 0; m_gnt = 0; m_rd = 0;
            m_fresh = 0; m_armed = 0; m_rv = 0; m_tick = 0;
            return;
        end
        m_gnt  = 0;
        m_rv   = 0;
        adv    = step_en && (m_cnt >= int'(div_val));
        m_tick = adv;
        if (step_en) m_cnt = adv ? 0 : m_cnt + 1;
        old = m_lfsr;
        if (old == 0) m_lfsr = 1;
        else if (adv) m_lfsr = lfsr_step(old);
        if (m_armed) begin
            m_armed = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_gnt == 0 && req[idx]) begin
                    m_gnt   = 1 << idx;
                    m_rd    = old;
                    m_rv    = 1;
                    m_ptr   = (idx + 1) % N;
                    m_fresh = 0;
                end
            end
        end else if (m_fresh && req != 0) begin
            m_armed = 1;
        end
        if (adv) m_fresh = 1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("lfsr_q",    32'(lfsr_q),    32'(m_lfsr));
        chk("tick",      32'(tick),      32'(m_tick));
        chk("gnt",       32'(gnt),       32'(m_gnt));
        chk("rnd_valid", 32'(rnd_valid), 32'(m_rv));
        chk("rnd_data",  32'(rnd_data),  32'(m_rd));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        bit rst_n; bit en; int dv; int rq;
        int e_lfsr; bit e_tick; int e_gnt; bit e_rv; int e_rd;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         nseen;
        int         order[5];
        int         data[5];
        int         hits;
        int         cur_div;
        logic [N-1:0] pend;

        // rst_n en dv rq | lfsr tick gnt rv rd
        tbl[0]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0,  2, 1, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0,  4, 1, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 0,  9, 1, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 18, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0,  5, 1, 0, 0, 0};
        tbl[7]  = '{1, 1, 3, 0,  5, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 3, 0,  5, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 3, 0,  5, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 3, 0, 11, 1, 0, 0, 0};
        tbl[11] = '{1, 1, 3, 0, 11, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 3, 0, 11, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 3, 0, 11, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 1, 0, 22, 1, 0, 0, 0};
        tbl[15] = '{1, 1, 1, 0, 22, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 1, 0, 12, 1, 0, 0, 0};
        tbl[17] = '{1, 1, 1, 0, 12, 0, 0, 0, 0};
        tbl[18] = '{1, 1, 1, 0, 25, 1, 0, 0, 0};
        tbl[19] = '{1, 0, 1, 4, 25, 0, 0, 0, 0};
        tbl[20] = '{1, 0, 1, 4, 25, 0, 4, 1, 25};
        tbl[21] = '{1, 0, 1, 4, 25, 0, 0, 0, 25};

        for (int r = 0; r < 22; r++) begin
            reset   = tbl[r].rst_n;
            step_en = tbl[r].en;
            div_val = DW'(tbl[r].dv);
            req     = N'(tbl[r].rq);
            cycle();
            chk("tbl_lfsr", 32'(lfsr_q),    32'(tbl[r].e_lfsr));
            chk("tbl_tick", 32'(tick),      32'(tbl[r].e_tick));
            chk("tbl_gnt",  32'(gnt),       32'(tbl[r].e_gnt));
            chk("tbl_rv",   32'(rnd_valid), 32'(tbl[r].e_rv));
            chk("tbl_rd",   32'(rnd_data),  32'(tbl[r].e_rd));
        end

        // Period: 31 advances return to 00001 and not earlier.
        step_en = 1'b0; div_val = '0; req = '0;
        do_reset();
        step_en = 1'b1;
        hits = 0;
        for (int i = 1; i <= 31; i++) begin
            cycle();
            if (i < 31 && lfsr_q == 5'd1) hits++;
        end
        chk("period_end",   32'(lfsr_q), 32'd1);
        chk("period_early", 32'(hits),   32'd0);

        // Round-robin with all requesters held high.
        do_reset();
        req = 4'b1111; div_val = DW'(4); step_en = 1'b1;
        nseen = 0;
        for (int i = 0; i < 40 && nseen < 5; i++) begin
            cycle();
            if (rnd_valid) begin
                order[nseen] = int'(gnt);
                data[nseen]  = int'(rnd_data);
                nseen++;
            end
        end
        chk("rr_count", 32'(nseen), 32'd5);
        if (nseen == 5) begin
            chk("rr_order0", 32'(order[0]), 32'd1);
            chk("rr_order1", 32'(order[1]), 32'd2);
            chk("rr_order2", 32'(order[2]), 32'd4);
            chk("rr_order3", 32'(order[3]), 32'd8);
            chk("rr_order4", 32'(order[4]), 32'd1);
            for (int a = 0; a < 5; a++)
                for (int b = a + 1; b < 5; b++)
                    chk("rr_unique", 32'(data[a] == data[b]), 32'd0);
        end

        // Single consumer: one grant per tick, never repeated between ticks.
        req = '0;
        do_reset();
        req = 4'b0100; div_val = DW'(9);
        nseen = 0; hits = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (rnd_valid) nseen++;
            if (gnt != 4'b0000 && gnt != 4'b0100) hits++;
        end
        chk("single_count", 32'(nseen), 32'd3);
        chk("single_wrong", 32'(hits),  32'd0);

        // Grant/advance collision with div_val=0.
        req = '0;
        do_reset();
        div_val = '0; req = 4'b0001;
        cycle(); cycle(); cycle();
        chk("coll_gnt1",  32'(gnt),      32'd1);
        chk("coll_rd1",   32'(rnd_data), 32'd4);
        chk("coll_lfsr1", 32'(lfsr_q),   32'd9);
        cycle();
        chk("coll_gap",   32'(rnd_valid), 32'd0);
        cycle();
        chk("coll_gnt2",  32'(gnt),      32'd1);
        chk("coll_rd2",   32'(rnd_data), 32'd18);

        // Reset landing on the would-be grant edge.
        req = '0;
        do_reset();
        req = 4'b0010;
        cycle(); cycle(); cycle();
        chk("mid_pre_gnt", 32'(gnt), 32'd2);
        cycle();
        reset = 1'b0;
        cycle();
        chk("mid_gnt",  32'(gnt),       32'd0);
        chk("mid_rv",   32'(rnd_valid), 32'd0);
        chk("mid_lfsr", 32'(lfsr_q),    32'd1);
        chk("mid_rd",   32'(rnd_data),  32'd0);
        reset = 1'b1;
        req = 4'b1010;
        cycle(); cycle(); cycle();
        chk("mid_post_gnt", 32'(gnt), 32'd2);

        // Randomized traffic: requesters hold until granted, occasionally cancel.
        req = '0;
        do_reset();
        pend = '0;
        cur_div = 2;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) cur_div = int'($urandom_range(0, 6));
            div_val = DW'(cur_div);
            step_en = ($urandom_range(0, 9) != 0);
            reset   = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
                else if (pend[i] && $urandom_range(0, 29) == 0) pend[i] = 1'b0;
            end
            req = pend;
            cycle();
            pend = pend & ~N'(m_gnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
